// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like slave port between fetch and data masters.
// Data wins ties; an in-order ID FIFO steers responses back.
module sram_req_arbiter #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [31:0]      inst_addr,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             bus_req,
  output logic             bus_wr,
  output logic [1:0]       bus_size,
  output logic [31:0]      bus_addr,
  output logic [3:0]       bus_wstrb,
  output logic [31:0]      bus_wdata,
  input  logic             bus_addr_ok,
  input  logic             bus_data_ok,
  input  logic [31:0]      bus_rdata,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_unexp
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } id_e;

  logic             lock_valid;
  id_e              lock_id;
  id_e              owner;
  id_e              head;
  logic [DEPTH-1:0] fifo;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             own_req;
  logic             accept;
  logic             pop;

  always_comb begin
    owner = INST;
    if (lock_valid)
      owner = lock_id;
    else if (data_req)
      owner = DATA;
  end

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  always_comb begin
    own_req   = inst_req;
    bus_wr    = inst_wr;
    bus_size  = inst_size;
    bus_addr  = inst_addr;
    bus_wstrb = inst_wstrb;
    bus_wdata = inst_wdata;
    if (owner == DATA) begin
      own_req   = data_req;
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_addr  = data_addr;
      bus_wstrb = data_wstrb;
      bus_wdata = data_wdata;
    end
  end

  // Full masks the request even when a pop frees a slot this cycle.
  assign bus_req = own_req & ~full;
  assign accept  = bus_req & bus_addr_ok;
  assign pop     = bus_data_ok & ~empty;
  assign head    = id_e'(fifo[rptr]);

  assign inst_addr_ok = accept & (owner == INST);
  assign data_addr_ok = accept & (owner == DATA);
  assign inst_data_ok = pop & (head == INST);
  assign data_data_ok = pop & (head == DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign outstanding  = cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid <= 1'b0;
      lock_id    <= INST;
    end else if (accept) begin
      lock_valid <= 1'b0;
    end else if (bus_req) begin
      lock_valid <= 1'b1;
      lock_id    <= owner;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (accept) begin
        fifo[wptr] <= owner;
        wptr       <= wptr + PW'(1);
      end
      if (pop)
        rptr <= rptr + PW'(1);
      if (accept && !pop)
        cnt <= cnt + CNT_W'(1);
      else if (!accept && pop)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      err_unexp <= 1'b0;
    else if (bus_data_ok && empty)
      err_unexp <= 1'b1;
  end

endmodule
